partition_step_scheduler: RTL and testbench
===========================================

Name: partition_step_scheduler

Overview:
- Time-step controller for the partitioned real-time solver.
- On each simulation step tick it launches N_PART partition solvers and collects their done indications.
- When every partition has finished, it issues a one-cycle valuation strobe that drives control_valuation_sig of every inter-partition interface register, so all partitions exchange boundary values in the same cycle.
- It also detects step overruns and solver timeouts.

Parameters:
- N_PART, 4, number of partition solvers sequenced (1..16).
- TMO_W, 16, width of the timeout counter and timeout_limit.
- CNT_W, 32, width of the committed-step counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- enable  in  1  scheduler enable; sampled only in IDLE
- step_tick  in  1  one-cycle step request from the time-base
- timeout_limit  in  TMO_W  max WAIT cycles per step; 0 disables the timeout
- err_clr  in  1  clears the sticky overrun_err and timeout_err flags
- part_done  in  N_PART  per-partition completion pulse or level
- part_start  out  N_PART  one-cycle start pulse to all partitions
- valuation_sig  out  1  one-cycle latch strobe to the interface registers
- busy  out  1  high whenever state is not IDLE
- done_mask  out  N_PART  partitions that have reported done in the current step
- step_count  out  CNT_W  number of committed steps
- overrun_err  out  1  sticky: a tick arrived while busy
- timeout_err  out  1  sticky: a step was aborted on timeout

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - part_start = 0, valuation_sig = 0, busy = 0
  - done_mask = 0, step_count = 0
  - overrun_err = 0, timeout_err = 0
- States: IDLE, START, WAIT, LATCH.
- IDLE:
  - If enable = 1 and step_tick = 1 at an edge, go to START.
  - Also clear done_mask and the timeout counter at that edge.
  - Otherwise stay; a tick with enable = 0 is ignored silently.
- START (exactly 1 cycle):
  - part_start = all ones for this cycle only.
  - Next state is WAIT.
  - part_done is ignored in START.
- WAIT:
  - Each edge: done_mask <= done_mask | part_done.
  - The timeout counter increments by 1 per cycle and saturates at all ones.
  - all_done = (done_mask | part_done) == all ones.
  - If all_done, go to LATCH.
  - Else if timeout_limit != 0 and counter + 1 >= timeout_limit, set timeout_err, go to IDLE, and do NOT strobe. Interface registers keep their previous values.
  - If all_done and the timeout are both true in the same cycle, all_done wins.
- LATCH (exactly 1 cycle):
  - valuation_sig = 1.
  - At the end of the cycle, step_count <= step_count + 1 (wraps modulo 2^CNT_W), and the state returns to IDLE.
- Latency: tick sampled at edge k.
  - part_start is high in cycle k+1.
  - Done bits are accepted from cycle k+2 onward.
  - If all done is seen at edge m, valuation_sig is high in cycle m+1 and busy drops in cycle m+2.
  - Minimum tick-to-strobe is 3 cycles.
- Overrun:
  - A step_tick at any edge while state != IDLE sets overrun_err.
  - The tick is dropped, not queued.
  - The step in progress is unaffected.
- enable deasserted mid-step: the current step completes normally.
- A part_done bit already set in done_mask stays set. Repeated pulses have no effect.
- err_clr:
  - Clears both sticky flags at the edge.
  - If a new error event occurs in the same cycle, the set wins.
- Reset mid-step:
  - Immediately returns to IDLE with all outputs at reset values.
  - No valuation_sig is produced.
- busy is derived registered from the next state, so it is high exactly from cycle k+1 through the LATCH cycle (or through the final WAIT cycle on timeout).

Test Plan:
- Normal step (N_PART=4, timeout_limit=100):
  - Stimulus: tick; done pulses on partitions 0, 2, 1, 3 in WAIT cycles 1, 2, 4, 7.
  - Response: part_start = 4'b1111 for one cycle; done_mask progresses 0001→0101→0111→1111; valuation_sig is high exactly one cycle after the last done; step_count = 1; no error flags.
- Simultaneous done: all four done bits in the first WAIT cycle → valuation_sig 3 cycles after the tick edge.
- Timeout:
  - Stimulus: timeout_limit=5; partition 3 never reports done.
  - Response: after 5 WAIT cycles, timeout_err = 1; no valuation_sig; step_count unchanged; busy = 0. A following good step commits, giving step_count = 1.
- Overrun:
  - Stimulus: second tick during WAIT.
  - Response: overrun_err = 1; only one valuation_sig; step_count increments by 1.
  - Then err_clr → both flags 0. err_clr in the same cycle as a new overrun tick → overrun_err stays 1.
- Enable gating and reset:
  - Tick with enable = 0 → no part_start, no flags.
  - rst asserted during WAIT → all outputs 0 immediately; no strobe afterwards.
  - step_count preset near 2^CNT_W−1 (CNT_W=4 build): 15 steps then 1 more → step_count wraps to 0.

Source files
------------

// File: rtl/partition_step_scheduler_if.sv
// Control/status bundle between the step scheduler and its partition solvers / time-base.
// The master side is the scheduler; the slave side is whatever drives ticks and consumes strobes.
interface partition_step_scheduler_if #(
  parameter int N_PART = 4,
  parameter int TMO_W  = 16,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic              step_tick;
  logic [TMO_W-1:0]  timeout_limit;
  logic              err_clr;
  logic [N_PART-1:0] part_done;
  logic [N_PART-1:0] part_start;
  logic              valuation_sig;
  logic              busy;
  logic [N_PART-1:0] done_mask;
  logic [CNT_W-1:0]  step_count;
  logic              overrun_err;
  logic              timeout_err;

  modport master (
    input  enable, step_tick, timeout_limit, err_clr, part_done,
    output part_start, valuation_sig, busy, done_mask, step_count,
           overrun_err, timeout_err
  );

  modport slave (
    output enable, step_tick, timeout_limit, err_clr, part_done,
    input  part_start, valuation_sig, busy, done_mask, step_count,
           overrun_err, timeout_err
  );
endinterface

// File: rtl/partition_step_scheduler.sv
// Time-step controller: launches all partition solvers on a tick, gathers their done
// indications and fires a single valuation strobe so every partition exchanges boundaries together.
module partition_step_scheduler #(
  parameter int N_PART = 4,
  parameter int TMO_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  partition_step_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic [N_PART-1:0] ALL_DONE = {N_PART{1'b1}};
  localparam logic [TMO_W-1:0]  TMO_MAX  = {TMO_W{1'b1}};

  state_t            state_q, state_d;
  logic [N_PART-1:0] doneMask_q, doneMask_d;
  logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
  logic [CNT_W-1:0]  stepCount_q, stepCount_d;
  logic              overrunErr_q, overrunErr_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic [N_PART-1:0] partStart_q;
  logic              valuation_q;
  logic              busy_q;

  logic              allDone;
  logic [TMO_W:0]    tmoNext;
  logic              tmoExpired;

  // Timeout compare is done one bit wider so a saturated counter cannot wrap past the limit.
  assign allDone    = ((doneMask_q | bus.part_done) == ALL_DONE);
  assign tmoNext    = {1'b0, tmoCnt_q} + (TMO_W+1)'(1);
  assign tmoExpired = (bus.timeout_limit != '0) && (tmoNext >= {1'b0, bus.timeout_limit});

  always_comb begin
    state_d      = state_q;
    doneMask_d   = doneMask_q;
    tmoCnt_d     = tmoCnt_q;
    stepCount_d  = stepCount_q;
    overrunErr_d = overrunErr_q;
    timeoutErr_d = timeoutErr_q;

    if (bus.err_clr) begin
      overrunErr_d = 1'b0;
      timeoutErr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable && bus.step_tick) begin
          state_d    = S_START;
          doneMask_d = '0;
          tmoCnt_d   = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        doneMask_d = doneMask_q | bus.part_done;
        if (tmoCnt_q != TMO_MAX) begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
        // A step that completes on the same edge its budget runs out still commits.
        if (allDone) begin
          state_d = S_LATCH;
        end else if (tmoExpired) begin
          state_d      = S_IDLE;
          timeoutErr_d = 1'b1;
        end
      end
      S_LATCH: begin
        stepCount_d = stepCount_q + CNT_W'(1);
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ticks that land mid-step are dropped; only the sticky flag records them.
    if (bus.step_tick && (state_q != S_IDLE)) begin
      overrunErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      doneMask_q   <= '0;
      tmoCnt_q     <= '0;
      stepCount_q  <= '0;
      overrunErr_q <= 1'b0;
      timeoutErr_q <= 1'b0;
      partStart_q  <= '0;
      valuation_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      doneMask_q   <= doneMask_d;
      tmoCnt_q     <= tmoCnt_d;
      stepCount_q  <= stepCount_d;
      overrunErr_q <= overrunErr_d;
      timeoutErr_q <= timeoutErr_d;
      partStart_q  <= (state_d == S_START) ? ALL_DONE : '0;
      valuation_q  <= (state_d == S_LATCH);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign bus.part_start    = partStart_q;
  assign bus.valuation_sig = valuation_q;
  assign bus.busy          = busy_q;
  assign bus.done_mask     = doneMask_q;
  assign bus.step_count    = stepCount_q;
  assign bus.overrun_err   = overrunErr_q;
  assign bus.timeout_err   = timeoutErr_q;

endmodule

// File: tb/tb_partition_step_scheduler.sv
// Directed bench for partition_step_scheduler: a 32-bit counter instance for the step
// scenarios and a 4-bit counter instance for the step_count wrap-around.
module tb_partition_step_scheduler;

  logic clk;
  logic rst;
  logic rstB;
  int   vectors;
  int   miscompares;

  partition_step_scheduler_if #(.N_PART(4), .TMO_W(16), .CNT_W(32)) busA ();
  partition_step_scheduler_if #(.N_PART(4), .TMO_W(16), .CNT_W(4))  busB ();

  partition_step_scheduler #(.N_PART(4), .TMO_W(16), .CNT_W(32)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.master)
  );

  partition_step_scheduler #(.N_PART(4), .TMO_W(16), .CNT_W(4)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic runStepB();
    busB.step_tick = 1'b1;
    applyStimulus();
    busB.step_tick = 1'b0;
    applyStimulus();
    busB.part_done = 4'b1111;
    applyStimulus();
    busB.part_done = 4'b0000;
    applyStimulus();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    rstB = 1'b1;
    busA.enable = 1'b0; busA.step_tick = 1'b0; busA.timeout_limit = 16'd100;
    busA.err_clr = 1'b0; busA.part_done = 4'b0000;
    busB.enable = 1'b0; busB.step_tick = 1'b0; busB.timeout_limit = 16'd0;
    busB.err_clr = 1'b0; busB.part_done = 4'b0000;
    applyStimulus();
    applyStimulus();

    checkOutput("rst_part_start", 32'(busA.part_start), 32'h0);
    checkOutput("rst_busy", 32'(busA.busy), 32'h0);
    checkOutput("rst_valuation", 32'(busA.valuation_sig), 32'h0);
    checkOutput("rst_step_count", busA.step_count, 32'h0);
    checkOutput("rst_errs", 32'({busA.overrun_err, busA.timeout_err}), 32'h0);
    rst  = 1'b0;
    rstB = 1'b0;
    applyStimulus();

    // Normal step: done on partitions 0,2,1,3 in WAIT cycles 1,2,4,7.
    busA.enable = 1'b1;
    busA.step_tick = 1'b1;
    applyStimulus();
    busA.step_tick = 1'b0;
    checkOutput("norm_start_pulse", 32'(busA.part_start), 32'hF);
    checkOutput("norm_busy_start", 32'(busA.busy), 32'h1);
    applyStimulus();
    checkOutput("norm_start_off", 32'(busA.part_start), 32'h0);
    busA.part_done = 4'b0001; applyStimulus();
    checkOutput("norm_mask_w1", 32'(busA.done_mask), 32'h1);
    busA.part_done = 4'b0100; applyStimulus();
    checkOutput("norm_mask_w2", 32'(busA.done_mask), 32'h5);
    busA.part_done = 4'b0000; applyStimulus();
    busA.part_done = 4'b0010; applyStimulus();
    checkOutput("norm_mask_w4", 32'(busA.done_mask), 32'h7);
    busA.part_done = 4'b0000; applyStimulus();
    applyStimulus();
    checkOutput("norm_no_early_strobe", 32'(busA.valuation_sig), 32'h0);
    busA.part_done = 4'b1000; applyStimulus();
    busA.part_done = 4'b0000;
    checkOutput("norm_strobe", 32'(busA.valuation_sig), 32'h1);
    checkOutput("norm_mask_full", 32'(busA.done_mask), 32'hF);
    checkOutput("norm_busy_latch", 32'(busA.busy), 32'h1);
    applyStimulus();
    checkOutput("norm_strobe_off", 32'(busA.valuation_sig), 32'h0);
    checkOutput("norm_busy_off", 32'(busA.busy), 32'h0);
    checkOutput("norm_count", busA.step_count, 32'd1);
    checkOutput("norm_errs", 32'({busA.overrun_err, busA.timeout_err}), 32'h0);

    // All partitions done in the first WAIT cycle: strobe three edges after the tick edge.
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0; applyStimulus();
    busA.part_done = 4'b1111; applyStimulus();
    busA.part_done = 4'b0000;
    checkOutput("simul_strobe", 32'(busA.valuation_sig), 32'h1);
    applyStimulus();
    checkOutput("simul_count", busA.step_count, 32'd2);

    // Timeout with partition 3 silent and a limit of 5 WAIT cycles.
    busA.timeout_limit = 16'd5;
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0; applyStimulus();
    busA.part_done = 4'b0111; applyStimulus();
    busA.part_done = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("tmo_still_busy", 32'(busA.busy), 32'h1);
      checkOutput("tmo_not_yet", 32'(busA.timeout_err), 32'h0);
    end
    applyStimulus();
    checkOutput("tmo_err", 32'(busA.timeout_err), 32'h1);
    checkOutput("tmo_busy", 32'(busA.busy), 32'h0);
    checkOutput("tmo_no_strobe", 32'(busA.valuation_sig), 32'h0);
    checkOutput("tmo_count", busA.step_count, 32'd2);
    checkOutput("tmo_mask", 32'(busA.done_mask), 32'h7);
    applyStimulus();
    checkOutput("tmo_no_late_strobe", 32'(busA.valuation_sig), 32'h0);

    // A good step after the timeout starts from a clean mask and commits.
    busA.timeout_limit = 16'd100;
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0;
    checkOutput("post_tmo_mask_clr", 32'(busA.done_mask), 32'h0);
    applyStimulus();
    busA.part_done = 4'b1111; applyStimulus();
    busA.part_done = 4'b0000; applyStimulus();
    checkOutput("post_tmo_count", busA.step_count, 32'd3);

    // Overrun: second tick in WAIT is dropped but flagged.
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0; applyStimulus();
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0;
    checkOutput("ovr_flag", 32'(busA.overrun_err), 32'h1);
    checkOutput("ovr_still_busy", 32'(busA.busy), 32'h1);
    busA.part_done = 4'b1111; applyStimulus();
    busA.part_done = 4'b0000;
    checkOutput("ovr_strobe", 32'(busA.valuation_sig), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("ovr_single_strobe", 32'(busA.valuation_sig), 32'h0);
    checkOutput("ovr_idle", 32'(busA.busy), 32'h0);
    checkOutput("ovr_count", busA.step_count, 32'd4);

    busA.err_clr = 1'b1; applyStimulus();
    busA.err_clr = 1'b0;
    checkOutput("clr_flags", 32'({busA.overrun_err, busA.timeout_err}), 32'h0);

    // err_clr coinciding with a fresh overrun tick: the set wins.
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0; applyStimulus();
    busA.step_tick = 1'b1;
    busA.err_clr   = 1'b1;
    applyStimulus();
    busA.step_tick = 1'b0;
    busA.err_clr   = 1'b0;
    checkOutput("clr_vs_set", 32'(busA.overrun_err), 32'h1);
    busA.part_done = 4'b1111; applyStimulus();
    busA.part_done = 4'b0000; applyStimulus();
    checkOutput("clr_vs_set_count", busA.step_count, 32'd5);
    busA.err_clr = 1'b1; applyStimulus();
    busA.err_clr = 1'b0;

    // Tick with enable low is ignored.
    busA.enable = 1'b0;
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0;
    checkOutput("dis_no_start", 32'(busA.part_start), 32'h0);
    checkOutput("dis_no_busy", 32'(busA.busy), 32'h0);
    checkOutput("dis_no_flags", 32'({busA.overrun_err, busA.timeout_err}), 32'h0);

    // Asynchronous reset in the middle of WAIT.
    busA.enable = 1'b1;
    busA.step_tick = 1'b1; applyStimulus();
    busA.step_tick = 1'b0; applyStimulus();
    busA.part_done = 4'b0011; applyStimulus();
    checkOutput("rstmid_mask_before", 32'(busA.done_mask), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_busy", 32'(busA.busy), 32'h0);
    checkOutput("rstmid_mask", 32'(busA.done_mask), 32'h0);
    checkOutput("rstmid_count", busA.step_count, 32'h0);
    busA.part_done = 4'b1111;
    applyStimulus();
    rst = 1'b0;
    busA.part_done = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("rstmid_no_strobe", 32'(busA.valuation_sig), 32'h0);
    end

    // 4-bit counter instance: 15 steps reach 4'hF, one more wraps to zero.
    checkOutput("wrap_reset", 32'(busB.step_count), 32'h0);
    busB.enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      runStepB();
    end
    checkOutput("wrap_at_max", 32'(busB.step_count), 32'hF);
    runStepB();
    checkOutput("wrap_to_zero", 32'(busB.step_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
